// File: rtl/wb_buffer_if.sv
// Bus bundle for the write-back buffer: dcache push side, miss lookup and
// the word-wide write port toward memory_control.
interface wb_buffer_if;
  logic        wb_push;
  logic [31:0] wb_addr;
  logic [31:0] wb_data0;
  logic [31:0] wb_data1;
  logic        wb_full;
  logic        wb_empty;
  logic [31:0] lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;

  modport master (
    output wb_push, wb_addr, wb_data0, wb_data1, lk_addr, dwait,
    input  wb_full, wb_empty, lk_hit, lk_data, dWEN, daddr, dstore
  );

  modport slave (
    input  wb_push, wb_addr, wb_data0, wb_data1, lk_addr, dwait,
    output wb_full, wb_empty, lk_hit, lk_data, dWEN, daddr, dstore
  );
endinterface

// File: rtl/wb_buffer.sv
// Write-back buffer: circular FIFO of dirty two-word blocks, coalescing of
// repeat evictions, miss lookup and a two-word drain toward memory.
module wb_buffer #(
  parameter int DEPTH = 4
) (
  input logic      CLK,
  input logic      RST,
  wb_buffer_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic              r_valid [DEPTH];
  logic [28:0]       r_addr  [DEPTH];
  logic [31:0]       r_data0 [DEPTH];
  logic [31:0]       r_data1 [DEPTH];
  logic [PTRW-1:0]   r_head;
  logic [PTRW-1:0]   r_tail;
  logic [PTRW:0]     r_count;
  logic [PTRW:0]     w_countNext;
  logic              w_full;
  logic              w_pop;
  logic              w_append;
  logic              w_coalHit;
  logic              w_coalesce;
  logic [PTRW-1:0]   w_coalIdx;
  logic [PTRW-1:0]   w_coalScan;
  logic [PTRW-1:0]   w_lkScan;
  logic              w_unused;

  assign w_unused    = ^{bus.wb_addr[2:0], bus.lk_addr[1:0]};
  assign w_full      = (r_count == DEPTH[PTRW:0]);
  assign w_pop       = (r_state == WORD1) && !bus.dwait;
  assign w_coalesce  = bus.wb_push && w_coalHit;
  assign w_append    = bus.wb_push && !w_coalHit && !w_full;
  assign w_countNext = r_count + {{PTRW{1'b0}}, w_append} - {{PTRW{1'b0}}, w_pop};

  assign bus.wb_full  = w_full;
  assign bus.wb_empty = (r_count == '0) && (r_state == IDLE);

  // Scan oldest to youngest so the youngest match wins; the in-flight head is excluded.
  always_comb begin
    w_coalHit  = 1'b0;
    w_coalIdx  = '0;
    w_coalScan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_coalScan = r_head + k[PTRW-1:0];
      if (r_valid[w_coalScan] && (r_addr[w_coalScan] == bus.wb_addr[31:3]) &&
          !((k == 0) && (r_state != IDLE))) begin
        w_coalHit = 1'b1;
        w_coalIdx = w_coalScan;
      end
    end
  end

  always_comb begin
    bus.lk_hit  = 1'b0;
    bus.lk_data = '0;
    w_lkScan    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_lkScan = r_head + k[PTRW-1:0];
      if (r_valid[w_lkScan] && (r_addr[w_lkScan] == bus.lk_addr[31:3])) begin
        bus.lk_hit  = 1'b1;
        bus.lk_data = bus.lk_addr[2] ? r_data1[w_lkScan] : r_data0[w_lkScan];
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    bus.dWEN    = 1'b0;
    bus.daddr   = '0;
    bus.dstore  = '0;
    case (r_state)
      IDLE: begin
        if (w_countNext != '0) w_stateNext = WORD0;
      end
      WORD0: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {r_addr[r_head], 3'b000};
        bus.dstore = r_data0[r_head];
        if (!bus.dwait) w_stateNext = WORD1;
      end
      WORD1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {r_addr[r_head], 3'b100};
        bus.dstore = r_data1[r_head];
        if (!bus.dwait) w_stateNext = (w_countNext != '0) ? WORD0 : IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  // Coalesce targets are never the head while draining, so the in-flight words stay put.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
        r_data0[i] <= '0;
        r_data1[i] <= '0;
      end
    end else begin
      if (w_append) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= bus.wb_addr[31:3];
        r_data0[r_tail] <= bus.wb_data0;
        r_data1[r_tail] <= bus.wb_data1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_coalesce) begin
        r_data0[w_coalIdx] <= bus.wb_data0;
        r_data1[w_coalIdx] <= bus.wb_data1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= w_countNext;
    end
  end
endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_wb_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [28:0] addr;
    logic [31:0] d0;
    logic [31:0] d1;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ent_t mq[$];
  int   wordsSent;

  logic        eFull, eEmpty, eWen, eHit;
  logic [31:0] eAddr, eStore, eData;

  wb_buffer_if bus ();

  wb_buffer #(.DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: a queue of pending blocks; wordsSent counts words of the front block already on the bus.
  task automatic modelEdge();
    int   ci;
    bit   popNow;
    int   preSize;
    ent_t e;
    if (rst) begin
      mq.delete();
      wordsSent = 0;
      return;
    end
    preSize = mq.size();
    popNow  = (wordsSent == 2) && !bus.dwait;
    ci      = -1;
    if (bus.wb_push) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].addr == bus.wb_addr[31:3] && (i != 0 || wordsSent == 0)) begin
          ci = i;
          break;
        end
      end
      if (ci >= 0) begin
        e    = mq[ci];
        e.d0 = bus.wb_data0;
        e.d1 = bus.wb_data1;
        mq[ci] = e;
      end else if (preSize < DEPTH) begin
        e.addr = bus.wb_addr[31:3];
        e.d0   = bus.wb_data0;
        e.d1   = bus.wb_data1;
        mq.push_back(e);
      end
    end
    if (popNow) e = mq.pop_front();
    if (wordsSent == 0) begin
      if (mq.size() != 0) wordsSent = 1;
    end else if (!bus.dwait) begin
      if (wordsSent == 1) wordsSent = 2;
      else                wordsSent = (mq.size() != 0) ? 1 : 0;
    end
  endtask

  task automatic computeExp();
    eFull  = (mq.size() == DEPTH);
    eEmpty = (mq.size() == 0) && (wordsSent == 0);
    eWen   = (wordsSent != 0);
    eAddr  = 32'h0;
    eStore = 32'h0;
    if (wordsSent == 1) begin
      eAddr  = {mq[0].addr, 3'b000};
      eStore = mq[0].d0;
    end else if (wordsSent == 2) begin
      eAddr  = {mq[0].addr, 3'b100};
      eStore = mq[0].d1;
    end
    eHit  = 1'b0;
    eData = 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == bus.lk_addr[31:3]) begin
        eHit  = 1'b1;
        eData = bus.lk_addr[2] ? mq[i].d1 : mq[i].d0;
        break;
      end
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [31:0] a, input logic [31:0] d0,
                       input logic [31:0] d1, input logic w, input logic [31:0] lk);
    bus.wb_push  = p;
    bus.wb_addr  = a;
    bus.wb_data0 = d0;
    bus.wb_data1 = d1;
    bus.dwait    = w;
    bus.lk_addr  = lk;
  endtask

  task automatic drainAll(output bit ok);
    ok = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      #1;
      if (bus.wb_empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checks++; if (bus.dWEN !== 1'b0) begin failures++; $display("FAIL reset_dwen got=%0h exp=0", bus.dWEN); end
    checks++; if (bus.daddr !== 32'h0) begin failures++; $display("FAIL reset_daddr got=%0h exp=0", bus.daddr); end
    checks++; if (bus.dstore !== 32'h0) begin failures++; $display("FAIL reset_dstore got=%0h exp=0", bus.dstore); end
    checks++; if (bus.wb_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", bus.wb_full); end
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", bus.wb_empty); end
    checks++; if (bus.lk_hit !== 1'b0 || bus.lk_data !== 32'h0) begin failures++; $display("FAIL reset_lookup got=%0h/%0h exp=0/0", bus.lk_hit, bus.lk_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h100, 32'hAAAA, 32'hBBBB, 1'b0, 32'h0);
    #1;
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL single_pre_empty got=%0h exp=1", bus.wb_empty); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++; if (bus.dWEN !== 1'b1 || bus.daddr !== 32'h100 || bus.dstore !== 32'hAAAA) begin
      failures++; $display("FAIL single_word0 got=%0h/%0h/%0h exp=1/100/aaaa", bus.dWEN, bus.daddr, bus.dstore); end
    checks++; if (bus.wb_empty !== 1'b0) begin failures++; $display("FAIL single_busy_empty got=%0h exp=0", bus.wb_empty); end
    tick();
    #1;
    checks++; if (bus.dWEN !== 1'b1 || bus.daddr !== 32'h104 || bus.dstore !== 32'hBBBB) begin
      failures++; $display("FAIL single_word1 got=%0h/%0h/%0h exp=1/104/bbbb", bus.dWEN, bus.daddr, bus.dstore); end
    tick();
    #1;
    checks++; if (bus.dWEN !== 1'b0 || bus.wb_empty !== 1'b1) begin
      failures++; $display("FAIL single_done got=%0h/%0h exp=0/1", bus.dWEN, bus.wb_empty); end
  endtask

  task automatic test_full_drop();
    logic [31:0] a;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000 * (i + 1);
      drive(1'b1, a, 32'hA000 + i, 32'hB000 + i, 1'b1, 32'h0);
      tick();
    end
    drive(1'b1, 32'h500, 32'h5555, 32'h6666, 1'b1, 32'h0);
    #1;
    checks++; if (bus.wb_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0h exp=1", bus.wb_full); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h500);
    #1;
    checks++; if (bus.lk_hit !== 1'b0) begin failures++; $display("FAIL full_dropped_lookup got=%0h exp=0", bus.lk_hit); end
    bus.dwait = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      a = 32'h1000 * (i / 2 + 1) + ((i % 2) * 4);
      checks++; if (bus.dWEN !== 1'b1 || bus.daddr !== a || bus.dstore !== ((i % 2) ? 32'hB000 + i / 2 : 32'hA000 + i / 2)) begin
        failures++; $display("FAIL full_drain_%0d got=%0h/%0h/%0h exp_addr=%0h", i, bus.dWEN, bus.daddr, bus.dstore, a); end
      tick();
    end
    #1;
    checks++; if (bus.wb_empty !== 1'b1 || bus.dWEN !== 1'b0) begin
      failures++; $display("FAIL full_drain_end got=%0h/%0h exp=1/0", bus.wb_empty, bus.dWEN); end
    drainAll(ok);
  endtask

  task automatic test_coalesce();
    logic [31:0] expA [6];
    logic [31:0] expD [6];
    bit ok;
    expA = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h100, 32'h104};
    expD = '{32'h1, 32'h2, 32'h1234, 32'h5678, 32'h9, 32'hA};
    drive(1'b1, 32'h100, 32'h1, 32'h2, 1'b1, 32'h0);       tick();
    drive(1'b1, 32'h200, 32'h3, 32'h4, 1'b1, 32'h0);       tick();
    drive(1'b1, 32'h203, 32'h1234, 32'h5678, 1'b1, 32'h0); tick();
    drive(1'b1, 32'h100, 32'h9, 32'hA, 1'b1, 32'h0);       tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h104);
    #1;
    checks++; if (bus.lk_hit !== 1'b1 || bus.lk_data !== 32'hA) begin
      failures++; $display("FAIL coal_youngest got=%0h/%0h exp=1/a", bus.lk_hit, bus.lk_data); end
    checks++; if (bus.wb_full !== 1'b0) begin failures++; $display("FAIL coal_count got_full=%0h exp=0", bus.wb_full); end
    bus.dwait = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (bus.dWEN !== 1'b1 || bus.daddr !== expA[i] || bus.dstore !== expD[i]) begin
        failures++; $display("FAIL coal_drain_%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.dWEN, bus.daddr, bus.dstore, expA[i], expD[i]); end
      tick();
    end
    #1;
    checks++; if (bus.wb_empty !== 1'b1) begin failures++; $display("FAIL coal_end got=%0h exp=1", bus.wb_empty); end
    drainAll(ok);
  endtask

  task automatic test_lookup();
    bit ok;
    drive(1'b1, 32'h108, 32'h1111, 32'hBEEF, 1'b1, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h10C);
    #1;
    checks++; if (bus.lk_hit !== 1'b1 || bus.lk_data !== 32'hBEEF) begin
      failures++; $display("FAIL lookup_word1 got=%0h/%0h exp=1/beef", bus.lk_hit, bus.lk_data); end
    bus.lk_addr = 32'h109;
    #1;
    checks++; if (bus.lk_hit !== 1'b1 || bus.lk_data !== 32'h1111) begin
      failures++; $display("FAIL lookup_word0 got=%0h/%0h exp=1/1111", bus.lk_hit, bus.lk_data); end
    bus.lk_addr = 32'h300;
    #1;
    checks++; if (bus.lk_hit !== 1'b0 || bus.lk_data !== 32'h0) begin
      failures++; $display("FAIL lookup_miss got=%0h/%0h exp=0/0", bus.lk_hit, bus.lk_data); end
    drainAll(ok);
    checks++; if (!ok) begin failures++; $display("FAIL lookup_drain_timeout got=busy exp=empty"); end
  endtask

  task automatic test_full_pop();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h7000 + 32'h100 * i, 32'hC0 + i, 32'hD0 + i, 1'b1, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h9000, 32'hE0, 32'hE1, 1'b0, 32'h0);
    #1;
    checks++; if (bus.wb_full !== 1'b1 || bus.daddr !== 32'h7004) begin
      failures++; $display("FAIL fullpop_pre got=%0h/%0h exp=1/7004", bus.wb_full, bus.daddr); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h9000);
    #1;
    checks++; if (bus.wb_full !== 1'b0) begin failures++; $display("FAIL fullpop_notfull got=%0h exp=0", bus.wb_full); end
    checks++; if (bus.lk_hit !== 1'b0) begin failures++; $display("FAIL fullpop_dropped got=%0h exp=0", bus.lk_hit); end
    checks++; if (bus.daddr !== 32'h7100 || bus.dstore !== 32'hC1) begin
      failures++; $display("FAIL fullpop_next got=%0h/%0h exp=7100/c1", bus.daddr, bus.dstore); end
    drainAll(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fullpop_drain_timeout got=busy exp=empty"); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4000 + 32'h100 * i, 32'h10 + i, 32'h20 + i, 1'b1, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h4100);
    #1;
    checks++; if (bus.dWEN !== 1'b1 || bus.daddr !== 32'h4000) begin
      failures++; $display("FAIL rstmid_before got=%0h/%0h exp=1/4000", bus.dWEN, bus.daddr); end
    rst = 1'b1;
    #1;
    checks++; if (bus.dWEN !== 1'b0 || bus.wb_empty !== 1'b1 || bus.lk_hit !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got=%0h/%0h/%0h exp=0/1/0", bus.dWEN, bus.wb_empty, bus.lk_hit); end
    tick();
    rst = 1'b0;
    bus.dwait = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.dWEN !== 1'b0) begin failures++; $display("FAIL rstmid_after_%0d got=%0h exp=0", i, bus.dWEN); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    bit ok;
    pool = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 2) == 0, pool[$urandom % 6] | ($urandom % 8),
            $urandom, $urandom, ($urandom % 3) == 0, pool[$urandom % 6] | ($urandom % 8));
      #1;
      computeExp();
      checks++; if (bus.wb_full !== eFull) begin failures++; $display("FAIL rnd_full c=%0d got=%0h exp=%0h", c, bus.wb_full, eFull); end
      checks++; if (bus.wb_empty !== eEmpty) begin failures++; $display("FAIL rnd_empty c=%0d got=%0h exp=%0h", c, bus.wb_empty, eEmpty); end
      checks++; if (bus.dWEN !== eWen) begin failures++; $display("FAIL rnd_dwen c=%0d got=%0h exp=%0h", c, bus.dWEN, eWen); end
      checks++; if (bus.daddr !== eAddr) begin failures++; $display("FAIL rnd_daddr c=%0d got=%0h exp=%0h", c, bus.daddr, eAddr); end
      checks++; if (bus.dstore !== eStore) begin failures++; $display("FAIL rnd_dstore c=%0d got=%0h exp=%0h", c, bus.dstore, eStore); end
      checks++; if (bus.lk_hit !== eHit) begin failures++; $display("FAIL rnd_lkhit c=%0d got=%0h exp=%0h", c, bus.lk_hit, eHit); end
      checks++; if (bus.lk_data !== eData) begin failures++; $display("FAIL rnd_lkdata c=%0d got=%0h exp=%0h", c, bus.lk_data, eData); end
      tick();
    end
    drainAll(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rnd_drain_timeout got=busy exp=empty"); end
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    checks    = 0;
    failures  = 0;
    wordsSent = 0;
    mq.delete();
    test_reset();
    test_single();
    test_full_drop();
    test_coalesce();
    test_lookup();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
